// File: rtl/booth_mult_if.sv
// Handshake/data bundle for the sequential Booth multiplier booth_mult.
// The master (the multdiv wrapper or the bench) drives operands and start; the slave returns the result.
interface booth_mult_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_mult.sv
// Sequential signed WIDTHxWIDTH Booth multiplier, one Booth step per clock, low WIDTH bits returned.
// Define BOOTH_RADIX4_EN for modified (radix-4) Booth: two bits per step, half the latency.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    booth_mult_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           count;
    logic signed [WIDTH-1:0] m_reg;
    logic signed [WIDTH-1:0] u_reg;
    logic [WIDTH-1:0]        l_reg;
    logic                    q_m1;
    logic signed [WIDTH-1:0] u_nxt;
    logic [WIDTH-1:0]        l_nxt;
    logic                    q_nxt;
    logic [WIDTH-1:0]        result_reg;
    logic                    exc_reg;
    logic                    last_step;

    assign last_step = (count == CW'(STEPS - 1));

`ifdef BOOTH_RADIX4_EN
    // Sum is WIDTH+2 wide so +/-2M never overflows before the 2-bit arithmetic shift.
    logic signed [WIDTH+1:0] u_ext, m_ext, sum;
    always_comb begin
        u_ext = {{2{u_reg[WIDTH-1]}}, u_reg};
        m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};
        sum   = u_ext;
        case ({l_reg[1:0], q_m1})
            3'b001, 3'b010: sum = u_ext + m_ext;
            3'b011:         sum = u_ext + (m_ext <<< 1);
            3'b100:         sum = u_ext - (m_ext <<< 1);
            3'b101, 3'b110: sum = u_ext - m_ext;
            default:        sum = u_ext;
        endcase
        u_nxt = sum[WIDTH+1:2];
        l_nxt = {sum[1:0], l_reg[WIDTH-1:2]};
        q_nxt = l_reg[1];
    end
`else
    // Sum is WIDTH+1 wide; its sign becomes the new U MSB after the 1-bit shift.
    logic signed [WIDTH:0] u_ext, m_ext, sum;
    always_comb begin
        u_ext = {u_reg[WIDTH-1], u_reg};
        m_ext = {m_reg[WIDTH-1], m_reg};
        sum   = u_ext;
        case ({l_reg[0], q_m1})
            2'b01:   sum = u_ext + m_ext;
            2'b10:   sum = u_ext - m_ext;
            default: sum = u_ext;
        endcase
        u_nxt = sum[WIDTH:1];
        l_nxt = {sum[0], l_reg[WIDTH-1:1]};
        q_nxt = l_reg[0];
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ctrl_MULT) state_nxt = RUN;
            RUN:     if (bus.ctrl_MULT) state_nxt = RUN;
                     else if (last_step) state_nxt = DONE;
            DONE:    state_nxt = bus.ctrl_MULT ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            m_reg      <= '0;
            u_reg      <= '0;
            l_reg      <= '0;
            q_m1       <= 1'b0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
        end else begin
            state <= state_nxt;
            // A start in any state (including RUN) re-latches operands and discards the old run.
            if (bus.ctrl_MULT) begin
                m_reg <= bus.data_operandA;
                u_reg <= '0;
                l_reg <= bus.data_operandB;
                q_m1  <= 1'b0;
                count <= '0;
            end else if (state == RUN) begin
                u_reg <= u_nxt;
                l_reg <= l_nxt;
                q_m1  <= q_nxt;
                count <= count + CW'(1);
                if (last_step) begin
                    result_reg <= l_nxt;
                    exc_reg    <= (u_nxt != {WIDTH{l_nxt[WIDTH-1]}});
                end
            end
        end
    end

    always_comb begin
        bus.data_result    = result_reg;
        bus.data_exception = exc_reg;
        bus.data_resultRDY = (state == DONE);
        bus.busy           = (state == RUN);
    end
endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corner cases, random operands, restart,
// mid-run reset and back-to-back start, all compared against a 64-bit arithmetic reference.
module tb_booth_mult;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    booth_mult_if #(.WIDTH(32)) bus ();

    booth_mult #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Waits (bounded) for RDY after a start edge and checks latency, value, exception and flags.
    task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input string tag);
        longint      p;
        logic [31:0] er;
        logic        ee;
        logic [31:0] prev;
        int          n;
        logic        hold_ok;
        logic        busy_ok;
        p       = longint'(signed'(a)) * longint'(signed'(b));
        er      = p[31:0];
        ee      = (p != longint'(signed'(er)));
        prev    = bus.data_result;
        n       = 0;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        while (n < LAT + 8) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.data_resultRDY === 1'b1) break;
            if (bus.data_result !== prev) hold_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, ".latency"}, 64'(n), 64'(LAT));
        check({tag, ".result"}, 64'(bus.data_result), 64'(er));
        check({tag, ".exception"}, 64'(bus.data_exception), 64'(ee));
        check({tag, ".busy_at_rdy"}, 64'(bus.busy), 64'd0);
        check({tag, ".hold_and_busy"}, {62'd0, hold_ok, busy_ok}, 64'd3);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        start(a, b);
        wait_result(a, b, tag);
        @(posedge clock);
        #1;
        check({tag, ".rdy_single"}, 64'(bus.data_resultRDY), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, r1;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd5;
        repeat (3) @(posedge clock);
        #1;
        check("reset.result", 64'(bus.data_result), 64'd0);
        check("reset.exception", 64'(bus.data_exception), 64'd0);
        check("reset.rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset.busy", 64'(bus.busy), 64'd0);
        bus.ctrl_MULT = 1'b0;
        reset         = 1'b0;
        @(posedge clock);
        #1;

        run_op(32'd7, 32'hFFFF_FFFD, "d7xm3");
        run_op(32'h7FFF_FFFF, 32'd2, "dmaxx2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "dminxm1");
        run_op(32'h0000_FFFF, 32'h0001_0000, "dffffx10000");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dm1xm1");
        run_op(32'h8000_0000, 32'h8000_0000, "dminxmin");
        run_op(32'd0, 32'h1234_5678, "d0xb");
        run_op(32'h8765_4321, 32'd0, "dax0");

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($signed(16'($urandom))) : $urandom;
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        // Restart: second start ten edges after the first; only one RDY, for 6*7.
        start(32'd5, 32'd5);
        r1 = 32'd0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY !== 1'b0) r1 = r1 + 32'd1;
        end
        check("restart.no_early_rdy", 64'(r1), 64'd0);
        start(32'd6, 32'd7);
        wait_result(32'd6, 32'd7, "restart");

        // Reset mid-run clears everything and suppresses RDY.
        start(32'd9, 32'd9);
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset.outputs",
              {30'd0, bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
        r1 = 32'd0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY !== 1'b0) r1 = r1 + 32'd1;
        end
        check("midreset.no_rdy", 64'(r1), 64'd0);
        run_op(32'd3, 32'd4, "after_reset");

        // Back-to-back: new start issued during the DONE cycle.
        start(32'hFFFF_FFF0, 32'd3);
        wait_result(32'hFFFF_FFF0, 32'd3, "b2b_first");
        start(32'd1000, 32'hFFFF_FF00);
        wait_result(32'd1000, 32'hFFFF_FF00, "b2b_second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
